// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the waveform-encoder register file:
// response codes, write/read FSM state encodings and the data width.
package axil_pkg;

   localparam int DATA_W = 32;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE    = 2'd0,
      W_HAVE_AW = 2'd1,
      W_HAVE_W  = 2'd2,
      W_RESP    = 2'd3
   } wr_state_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_e;

endpackage

// File: rtl/axil_slave_regfile_if.sv
// AXI4-Lite bus bundle between the CPU-side master and the register file.
interface axil_slave_regfile_if #(
   parameter int ADDR_W = 32
);
   import axil_pkg::*;

   logic              AWVALID;
   logic              AWREADY;
   logic [ADDR_W-1:0] AWADDR;
   logic              WVALID;
   logic              WREADY;
   logic [3:0]        WSTRB;
   logic [DATA_W-1:0] WDATA;
   logic              BVALID;
   logic              BREADY;
   logic [1:0]        BRESP;
   logic              ARVALID;
   logic              ARREADY;
   logic [ADDR_W-1:0] ARADDR;
   logic              RVALID;
   logic              RREADY;
   logic [DATA_W-1:0] RDATA;
   logic [1:0]        RRESP;

   modport slave (
      input  AWVALID, AWADDR, WVALID, WSTRB, WDATA, BREADY, ARVALID, ARADDR, RREADY,
      output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
   );

   modport master (
      output AWVALID, AWADDR, WVALID, WSTRB, WDATA, BREADY, ARVALID, ARADDR, RREADY,
      input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
   );

endinterface

// File: rtl/axil_regbank.sv
// Register array with a byte-strobed write port, one combinational read port
// and a flattened view of every register for the downstream waveform logic.
module axil_regbank
   import axil_pkg::*;
#(
   parameter int NUM_REGS = 16
) (
   input  logic                         ACLK,
   input  logic                         ARESETn,
   input  logic                         wr_en,
   input  logic [$clog2(NUM_REGS)-1:0]  wr_idx,
   input  logic [DATA_W-1:0]            wr_data,
   input  logic [3:0]                   wr_strb,
   input  logic [$clog2(NUM_REGS)-1:0]  rd_idx,
   output logic [DATA_W-1:0]            rd_data,
   output logic [NUM_REGS*DATA_W-1:0]   regs_q
);

   logic [DATA_W-1:0] regs [NUM_REGS];

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) begin
               regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

   // Read sees the value before any same-edge write lands.
   assign rd_data = regs[rd_idx];

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_q[g*DATA_W +: DATA_W] = regs[g];
   end

endmodule

// File: rtl/axil_slave_regfile.sv
// AXI4-Lite responder holding NUM_REGS control/status registers, one write and
// one read in flight. Define AXIL_SLAVE_SLVERR_EN to answer out-of-range with SLVERR.
module axil_slave_regfile
   import axil_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter int ADDR_W   = 32
) (
   input  logic                       ACLK,
   input  logic                       ARESETn,
   axil_slave_regfile_if.slave        axil,
   output logic [NUM_REGS*DATA_W-1:0] regs_q
);

   localparam int IDX_W = $clog2(NUM_REGS);
   localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_REGS * 4);

`ifdef AXIL_SLAVE_SLVERR_EN
   localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
   localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

   wr_state_e w_state, w_next;
   rd_state_e r_state, r_next;

   logic              awready_q, wready_q, arready_q;
   logic [ADDR_W-1:0] aw_addr_q;
   logic [DATA_W-1:0] w_data_q;
   logic [3:0]        w_strb_q;
   logic [1:0]        bresp_q, rresp_q;
   logic [DATA_W-1:0] rdata_q;

   logic              aw_hs, w_hs, ar_hs;
   logic              commit;
   logic [ADDR_W-1:0] cm_addr;
   logic [DATA_W-1:0] cm_data;
   logic [3:0]        cm_strb;
   logic              cm_in_range, ar_in_range;
   logic [DATA_W-1:0] rd_data;

   assign aw_hs = axil.AWVALID & awready_q;
   assign w_hs  = axil.WVALID  & wready_q;
   assign ar_hs = axil.ARVALID & arready_q;

   // Commit uses whichever half was latched earlier plus the live half.
   always_comb begin
      w_next  = w_state;
      commit  = 1'b0;
      cm_addr = aw_addr_q;
      cm_data = w_data_q;
      cm_strb = w_strb_q;
      case (w_state)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               commit  = 1'b1;
               cm_addr = axil.AWADDR;
               cm_data = axil.WDATA;
               cm_strb = axil.WSTRB;
               w_next  = W_RESP;
            end else if (aw_hs) begin
               w_next = W_HAVE_AW;
            end else if (w_hs) begin
               w_next = W_HAVE_W;
            end
         end
         W_HAVE_AW: begin
            if (w_hs) begin
               commit  = 1'b1;
               cm_data = axil.WDATA;
               cm_strb = axil.WSTRB;
               w_next  = W_RESP;
            end
         end
         W_HAVE_W: begin
            if (aw_hs) begin
               commit  = 1'b1;
               cm_addr = axil.AWADDR;
               w_next  = W_RESP;
            end
         end
         W_RESP: begin
            if (axil.BREADY) begin
               w_next = W_IDLE;
            end
         end
         default: w_next = W_IDLE;
      endcase
   end

   assign cm_in_range = (cm_addr < ADDR_LIMIT);
   assign ar_in_range = (axil.ARADDR < ADDR_LIMIT);

   // Readies are registered from the next state so they are glitch-free and low in reset.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         w_state   <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bresp_q   <= RESP_OKAY;
      end else begin
         w_state   <= w_next;
         awready_q <= (w_next == W_IDLE) || (w_next == W_HAVE_W);
         wready_q  <= (w_next == W_IDLE) || (w_next == W_HAVE_AW);
         if (aw_hs) begin
            aw_addr_q <= axil.AWADDR;
         end
         if (w_hs) begin
            w_data_q <= axil.WDATA;
            w_strb_q <= axil.WSTRB;
         end
         if (commit) begin
            bresp_q <= cm_in_range ? RESP_OKAY : OOR_RESP;
         end
      end
   end

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs)        r_next = R_DATA;
         R_DATA:  if (axil.RREADY)  r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state   <= R_IDLE;
         arready_q <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         r_state   <= r_next;
         arready_q <= (r_next == R_IDLE);
         if (ar_hs) begin
            rdata_q <= ar_in_range ? rd_data : '0;
            rresp_q <= ar_in_range ? RESP_OKAY : OOR_RESP;
         end
      end
   end

   axil_regbank #(
      .NUM_REGS (NUM_REGS)
   ) u_regbank (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .wr_en   (commit & cm_in_range),
      .wr_idx  (cm_addr[IDX_W+1:2]),
      .wr_data (cm_data),
      .wr_strb (cm_strb),
      .rd_idx  (axil.ARADDR[IDX_W+1:2]),
      .rd_data (rd_data),
      .regs_q  (regs_q)
   );

   assign axil.AWREADY = awready_q;
   assign axil.WREADY  = wready_q;
   assign axil.BVALID  = (w_state == W_RESP);
   assign axil.BRESP   = bresp_q;
   assign axil.ARREADY = arready_q;
   assign axil.RVALID  = (r_state == R_DATA);
   assign axil.RDATA   = rdata_q;
   assign axil.RRESP   = rresp_q;

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Bench for axil_slave_regfile: transaction-level register model checked every
// cycle, directed corner cases with literal expectations, then randomized traffic.
module tb_axil_slave_regfile;
   import axil_pkg::*;

   localparam int NUM_REGS = 16;
   localparam int RW       = NUM_REGS * 32;

`ifdef AXIL_SLAVE_SLVERR_EN
   localparam logic [1:0] EXP_OOR = 2'b10;
`else
   localparam logic [1:0] EXP_OOR = 2'b00;
`endif

   logic          ACLK    = 1'b0;
   logic          ARESETn = 1'b1;
   logic [RW-1:0] regs_q;

   axil_slave_regfile_if #(.ADDR_W(32)) bus ();

   axil_slave_regfile #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (32)
   ) dut (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .axil    (bus.slave),
      .regs_q  (regs_q)
   );

   always #5 ACLK = ~ACLK;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic checkOutput(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeoutFail(input string name);
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL %s: timed out waiting on the DUT", name);
   endtask

   // Behavioural model: register contents and what each channel owes the master.
   logic [31:0] mem [NUM_REGS];
   bit          up, b_pend, r_pend, aw_have, w_have;
   logic [31:0] aw_addr_m, w_data_m, exp_rdata;
   logic [3:0]  w_strb_m;
   logic [1:0]  exp_bresp, exp_rresp;

   function automatic bit inRange(input logic [31:0] a);
      return a < 32'(NUM_REGS * 4);
   endfunction

   function automatic int regIndex(input logic [31:0] a);
      return int'((a / 4) % NUM_REGS);
   endfunction

   always @(negedge ACLK) begin : monitor
      logic [RW-1:0] ev;
      bit aw_hs, w_hs, ar_hs, b_done, r_done;
      for (int i = 0; i < NUM_REGS; i++) ev[32*i +: 32] = mem[i];
      if (!ARESETn) begin
         checkOutput("rst_awready", bus.AWREADY, 0);
         checkOutput("rst_wready",  bus.WREADY,  0);
         checkOutput("rst_arready", bus.ARREADY, 0);
         checkOutput("rst_bvalid",  bus.BVALID,  0);
         checkOutput("rst_rvalid",  bus.RVALID,  0);
         checkOutput("rst_bresp",   bus.BRESP,   0);
         checkOutput("rst_rresp",   bus.RRESP,   0);
         checkOutput("rst_rdata",   bus.RDATA,   0);
         checkOutput("rst_regs",    regs_q,      0);
         for (int i = 0; i < NUM_REGS; i++) mem[i] = '0;
         up = 0; b_pend = 0; r_pend = 0; aw_have = 0; w_have = 0;
      end else begin
         checkOutput("awready", bus.AWREADY, up && !b_pend && !aw_have);
         checkOutput("wready",  bus.WREADY,  up && !b_pend && !w_have);
         checkOutput("arready", bus.ARREADY, up && !r_pend);
         checkOutput("bvalid",  bus.BVALID,  b_pend);
         checkOutput("rvalid",  bus.RVALID,  r_pend);
         if (b_pend) checkOutput("bresp", bus.BRESP, exp_bresp);
         if (r_pend) begin
            checkOutput("rdata", bus.RDATA, exp_rdata);
            checkOutput("rresp", bus.RRESP, exp_rresp);
         end
         checkOutput("regs_q", regs_q, ev);

         // Work out what the coming edge does to the model.
         aw_hs  = bus.AWVALID && up && !b_pend && !aw_have;
         w_hs   = bus.WVALID  && up && !b_pend && !w_have;
         ar_hs  = bus.ARVALID && up && !r_pend;
         b_done = b_pend && bus.BREADY;
         r_done = r_pend && bus.RREADY;
         if (ar_hs) begin
            exp_rdata = inRange(bus.ARADDR) ? mem[regIndex(bus.ARADDR)] : 32'h0;
            exp_rresp = inRange(bus.ARADDR) ? 2'b00 : EXP_OOR;
         end
         if (r_done) r_pend = 0;
         if (ar_hs)  r_pend = 1;
         if (b_done) b_pend = 0;
         if (aw_hs) begin aw_have = 1; aw_addr_m = bus.AWADDR; end
         if (w_hs)  begin w_have = 1; w_data_m = bus.WDATA; w_strb_m = bus.WSTRB; end
         if (aw_have && w_have) begin
            if (inRange(aw_addr_m)) begin
               for (int b = 0; b < 4; b++)
                  if (w_strb_m[b]) mem[regIndex(aw_addr_m)][8*b +: 8] = w_data_m[8*b +: 8];
            end
            exp_bresp = inRange(aw_addr_m) ? 2'b00 : EXP_OOR;
            b_pend = 1; aw_have = 0; w_have = 0;
         end
         up = 1;
      end
   end

   // Master-side drivers; each starts and returns one time unit after a rising edge.
   task automatic applyStimulus(input string ch, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] strb);
      int n = 0;
      if (ch == "aw") begin bus.AWADDR = addr; bus.AWVALID = 1'b1; end
      else if (ch == "w") begin bus.WDATA = data; bus.WSTRB = strb; bus.WVALID = 1'b1; end
      else begin bus.ARADDR = addr; bus.ARVALID = 1'b1; end
      forever begin
         @(negedge ACLK);
         if ((ch == "aw" && bus.AWREADY) || (ch == "w" && bus.WREADY) ||
             (ch == "ar" && bus.ARREADY)) break;
         n++;
         if (n > 300) begin timeoutFail({ch, "_handshake"}); break; end
      end
      @(posedge ACLK); #1;
      if (ch == "aw") bus.AWVALID = 1'b0;
      else if (ch == "w") bus.WVALID = 1'b0;
      else bus.ARVALID = 1'b0;
   endtask

   task automatic waitB(output logic [1:0] resp);
      int n = 0;
      resp = 2'bxx;
      forever begin
         @(negedge ACLK);
         if (bus.BVALID) begin resp = bus.BRESP; break; end
         n++;
         if (n > 300) begin timeoutFail("bvalid_wait"); break; end
      end
      @(posedge ACLK); #1;
   endtask

   task automatic doRead(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
      int n = 0;
      data = 'x; resp = 'x;
      applyStimulus("ar", addr, 0, 0);
      forever begin
         @(negedge ACLK);
         if (bus.RVALID) begin data = bus.RDATA; resp = bus.RRESP; break; end
         n++;
         if (n > 300) begin timeoutFail("rvalid_wait"); break; end
      end
      @(posedge ACLK); #1;
   endtask

   task automatic doWrite(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
      fork
         applyStimulus("aw", addr, 0, 0);
         applyStimulus("w", 0, data, strb);
      join
      waitB(resp);
   endtask

   function automatic logic [31:0] randAddr();
      case ($urandom_range(0, 9))
         0:       return 32'h100 + 32'($urandom_range(0, 255));
         1:       return $urandom;
         default: return 32'($urandom_range(0, NUM_REGS - 1) * 4 + $urandom_range(0, 3));
      endcase
   endfunction

   bit rand_done = 0;

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0]   d;
      logic [1:0]    r;
      logic [RW-1:0] snap;

      bus.AWVALID = 0; bus.AWADDR = 0; bus.WVALID = 0; bus.WDATA = 0; bus.WSTRB = 0;
      bus.ARVALID = 0; bus.ARADDR = 0; bus.BREADY = 0; bus.RREADY = 0;
      #1 ARESETn = 1'b0;
      repeat (3) @(posedge ACLK);
      #2 ARESETn = 1'b1;
      @(posedge ACLK); #1;
      bus.BREADY = 1; bus.RREADY = 1;

      $display("[TB] aligned write and read-back");
      doWrite(32'h4, 32'hDEADBEEF, 4'hF, r);
      checkOutput("wr4_bresp", r, 2'b00);
      checkOutput("wr4_regs_q", regs_q[63:32], 32'hDEADBEEF);
      doRead(32'h4, d, r);
      checkOutput("rd4_data", d, 32'hDEADBEEF);
      checkOutput("rd4_resp", r, 2'b00);

      $display("[TB] W leads AW, then AW leads W");
      fork
         applyStimulus("w", 0, 32'h01020304, 4'hF);
         begin repeat (3) @(posedge ACLK); #1; applyStimulus("aw", 32'h8, 0, 0); end
      join
      waitB(r);
      fork
         applyStimulus("aw", 32'hC, 0, 0);
         begin repeat (3) @(posedge ACLK); #1; applyStimulus("w", 0, 32'h0A0B0C0D, 4'hF); end
      join
      waitB(r);
      doRead(32'h8, d, r);
      checkOutput("wlead_data", d, 32'h01020304);
      doRead(32'hE, d, r);
      checkOutput("awlead_data", d, 32'h0A0B0C0D);

      $display("[TB] byte strobes");
      doWrite(32'h8, 32'h11223344, 4'hF, r);
      doWrite(32'h8, 32'hAABBCCDD, 4'b0101, r);
      doRead(32'h8, d, r);
      checkOutput("strb_data", d, 32'h11BB33DD);
      doWrite(32'h8, 32'hFFFFFFFF, 4'h0, r);
      checkOutput("strb0_resp", r, 2'b00);
      checkOutput("strb0_regs_q", regs_q[95:64], 32'h11BB33DD);

      $display("[TB] out-of-range accesses");
      doRead(32'h100, d, r);
      checkOutput("oor_rdata", d, 0);
      checkOutput("oor_rresp", r, EXP_OOR);
      snap = regs_q;
      doWrite(32'h100, 32'h12345678, 4'hF, r);
      checkOutput("oor_bresp", r, EXP_OOR);
      checkOutput("oor_regs_unchanged", regs_q, snap);

      $display("[TB] response back-pressure");
      bus.BREADY = 0;
      doWrite(32'h14, 32'h55AA55AA, 4'hF, r);
      repeat (5) begin
         @(negedge ACLK);
         checkOutput("hold_bvalid", bus.BVALID, 1);
         checkOutput("hold_bresp", bus.BRESP, 0);
         checkOutput("hold_awready", bus.AWREADY, 0);
      end
      @(posedge ACLK); #1 bus.BREADY = 1;
      @(posedge ACLK); #1;
      bus.RREADY = 0;
      applyStimulus("ar", 32'h14, 0, 0);
      repeat (5) begin
         @(negedge ACLK);
         checkOutput("hold_rvalid", bus.RVALID, 1);
         checkOutput("hold_rdata", bus.RDATA, 32'h55AA55AA);
         checkOutput("hold_arready", bus.ARREADY, 0);
      end
      @(posedge ACLK); #1 bus.RREADY = 1;
      @(posedge ACLK); #1;

      $display("[TB] reset mid-transaction");
      bus.RREADY = 0;
      applyStimulus("ar", 32'h4, 0, 0);
      applyStimulus("aw", 32'h18, 0, 0);
      #1 ARESETn = 1'b0;
      #1;
      checkOutput("async_rst_awready", bus.AWREADY, 0);
      checkOutput("async_rst_rvalid", bus.RVALID, 0);
      checkOutput("async_rst_rdata", bus.RDATA, 0);
      checkOutput("async_rst_regs", regs_q, 0);
      repeat (2) @(posedge ACLK);
      #2 ARESETn = 1'b1;
      bus.RREADY = 1; bus.BREADY = 1;
      @(posedge ACLK); #1;
      doWrite(32'h18, 32'hCAFEF00D, 4'hF, r);
      checkOutput("post_rst_bresp", r, 2'b00);
      doRead(32'h18, d, r);
      checkOutput("post_rst_data", d, 32'hCAFEF00D);
      doRead(32'h4, d, r);
      checkOutput("post_rst_cleared", d, 0);

      $display("[TB] randomized traffic");
      fork
         begin
            fork
               for (int i = 0; i < 40; i++) begin
                  int k = $urandom_range(0, 3);
                  if (k > 0) begin repeat (k) @(posedge ACLK); #1; end
                  applyStimulus("aw", randAddr(), 0, 0);
               end
               for (int i = 0; i < 40; i++) begin
                  int k = $urandom_range(0, 3);
                  if (k > 0) begin repeat (k) @(posedge ACLK); #1; end
                  applyStimulus("w", 0, $urandom, 4'($urandom_range(0, 15)));
               end
               for (int i = 0; i < 40; i++) begin
                  int k = $urandom_range(0, 3);
                  if (k > 0) begin repeat (k) @(posedge ACLK); #1; end
                  applyStimulus("ar", randAddr(), 0, 0);
               end
            join
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               @(posedge ACLK); #1;
               bus.BREADY = 1'($urandom);
               bus.RREADY = 1'($urandom);
            end
            bus.BREADY = 1; bus.RREADY = 1;
         end
      join
      repeat (4) @(posedge ACLK);
      @(negedge ACLK);
      checkOutput("drain_bvalid", bus.BVALID, 0);
      checkOutput("drain_rvalid", bus.RVALID, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/axil_slave_regfile.md
# axil_slave_regfile

AXI4-Lite responder terminating the bus driven by the CPU-side AXI master in the waveform-encoder subsystem. It holds a bank of NUM_REGS 32-bit control/status registers and services one outstanding write and one outstanding read at a time, with independent write and read paths. Register contents are exported in parallel to downstream waveform logic.

## Interface
- NUM_REGS, 16, number of 32-bit registers; power of two, 2..256
- ADDR_W, 32, AXI address width
- ACLK  in  1  bus clock; all logic on rising edge
- ARESETn  in  1  asynchronous, active-low reset
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- AWADDR  in  ADDR_W  byte write address
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- WSTRB  in  4  byte-lane enables
- WDATA  in  32  write data
- BVALID  out  1  write response valid
- BREADY  in  1  master accepts response
- BRESP  out  2  write response
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- ARADDR  in  ADDR_W  byte read address
- RVALID  out  1  read data valid
- RREADY  in  1  master accepts read data
- RDATA  out  32  read data
- RRESP  out  2  read response
- regs_q  out  NUM_REGS*32  all register contents, reg i at [32i+31:32i]

## Operation
- Decode: index = addr[log2(NUM_REGS)+1:2]; addr[1:0] ignored; address in range iff addr < NUM_REGS*4.
- Write path FSM: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - W_IDLE: AW and W each accepted independently; both in same cycle -> commit, go W_RESP; only AW -> W_HAVE_AW; only W -> W_HAVE_W.
  - W_HAVE_AW: AWREADY=0, WREADY=1; on W handshake -> commit, W_RESP. W_HAVE_W symmetric.
  - W_RESP: AWREADY=WREADY=0, BVALID=1; on BREADY -> W_IDLE.
  - Commit: for each lane b with WSTRB[b]=1, reg[index][8b+7:8b] <= WDATA[8b+7:8b]. Out-of-range: no register changes.
- Read path FSM: R_IDLE (ARREADY=1), R_DATA (RVALID=1, ARREADY=0). AR handshake captures RDATA = reg[index] (0 if out of range); RDATA/RRESP held stable until RREADY, then R_IDLE.
- Responses: OKAY=2'b00, SLVERR=2'b10 (see Configuration).
- Same-edge read and write commit to one register: read returns pre-write value.
- WSTRB=0 write: no change, OKAY response.

## Timing
- Reset (async assert): AWREADY, WREADY, ARREADY, BVALID, RVALID = 0; BRESP, RRESP, RDATA = 0; all registers = 0; FSMs to idle. Readies rise on first ACLK edge after ARESETn deasserts.
- Readies are registered, computed from next state.
- Write latency: commit on edge of the later of the AW/W handshakes; BVALID high from that edge; regs_q reflects new value in the same cycle.
- Read latency: RVALID high from the edge sampling the AR handshake (1 cycle after ARVALID&ARREADY cycle).
- Back-to-back: BREADY already high when BVALID rises -> response completes in one cycle, readies return next cycle; max throughput one write per 2 cycles, one read per 2 cycles.
- Reset mid-transaction: transaction dropped, no response emitted; committed register values cleared to 0.

## Configuration
- AXIL_SLAVE_SLVERR_EN defined: out-of-range read/write returns SLVERR (2'b10); read data 0.
- Not defined: out-of-range accesses return OKAY, reads 0, writes ignored.
- In-range accesses always OKAY.

## Structure
- Package axil_pkg: AXI response constants (RESP_OKAY, RESP_SLVERR), write/read FSM state encodings, data width constant 32.
- Sub-module axil_regbank: register array with byte-strobe write port, one combinational read port, flattened regs_q output; both FSMs stay in the top.

## Test plan
- Write 0xDEADBEEF to 0x04 (AW and W same cycle, WSTRB=4'hF), then read 0x04 -> BRESP=OKAY, RDATA=0xDEADBEEF, regs_q[63:32]=0xDEADBEEF.
- W sent 3 cycles before AW, then AW before W -> both complete, each single BVALID, data correct; ready of already-accepted channel stays 0 while waiting.
- Reg 2 = 0x11223344, write 0xAABBCCDD with WSTRB=4'b0101 -> reads back 0x11BB33DD.
- Read 0x100 with NUM_REGS=16 -> RDATA=0; RRESP=SLVERR with AXIL_SLAVE_SLVERR_EN, OKAY without; write to 0x100 leaves all regs unchanged.
- Hold BREADY/RREADY low 5 cycles -> BVALID/RVALID, BRESP, RDATA stable, AWREADY/ARREADY stay 0 until accepted.
- Assert ARESETn low while in W_HAVE_AW and R_DATA -> all outputs 0 immediately, regs cleared, clean write succeeds after release.
